// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
// Optional parity stage is enabled by defining SIPO_FRAME_PARITY_EN.
package sipo_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial input, parallel output and status signals of sipo_frame_ctrl.
// parity_err exists only when SIPO_FRAME_PARITY_EN is defined.
interface sipo_frame_ctrl_if
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             sin;
  logic             sin_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             clr_ovr;
`ifdef SIPO_FRAME_PARITY_EN
  logic             parity_err;
`endif

  // Source/consumer side (drives the controller).
  modport master (
    output start, sin, sin_en, out_ready, clr_ovr,
`ifdef SIPO_FRAME_PARITY_EN
    input  parity_err,
`endif
    input  out_data, out_valid, busy, overrun
  );

  // Controller side.
  modport slave (
    input  start, sin, sin_en, out_ready, clr_ovr,
`ifdef SIPO_FRAME_PARITY_EN
    output parity_err,
`endif
    output out_data, out_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_frame_ctrl_shift.sv
// WIDTH-bit shift register; each enabled cycle shifts sin in at the LSB,
// so the first bit received ends up in the MSB.
module sipo_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d = {q_q[WIDTH-2:0], sin};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames a serial bit stream after a start pulse and hands the word to a
// valid/ready consumer. Define SIPO_FRAME_PARITY_EN for a trailing even-parity bit.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              reset_n,
  sipo_frame_ctrl_if.slave bus
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             shift_en;
  logic             complete;
  logic             drop;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shift_q;
`ifdef SIPO_FRAME_PARITY_EN
  logic             par_err;
  logic             parity_err_q, parity_err_d;
`endif

  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (shift_en),
    .sin      (bus.sin),
    .q        (shift_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    complete = 1'b0;
    // Without parity the word is captured on the same edge as the last shift,
    // so it is built from the register contents plus the incoming bit.
    word     = (shift_q << 1) | WIDTH'(bus.sin);
`ifdef SIPO_FRAME_PARITY_EN
    par_err  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bus.sin_en) begin
          shift_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
`ifdef SIPO_FRAME_PARITY_EN
            state_d = PARITY;
`else
            state_d  = IDLE;
            complete = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SIPO_FRAME_PARITY_EN
      PARITY: begin
        if (bus.sin_en) begin
          state_d  = IDLE;
          complete = 1'b1;
          word     = shift_q;
          par_err  = ^{shift_q, bus.sin};
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef SIPO_FRAME_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    drop = complete && out_valid_q && !bus.out_ready;
    if (complete && !drop) begin
      out_data_d  = word;
      out_valid_d = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
      parity_err_d = par_err;
`endif
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // A drop in the same cycle as a clear keeps the flag set.
    overrun_d = drop || (overrun_q && !bus.clr_ovr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef SIPO_FRAME_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;
`ifdef SIPO_FRAME_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl (WIDTH=4); delivered words are checked against a
// scoreboard queue, status signals inline. Honours SIPO_FRAME_PARITY_EN.
module tb_sipo_frame_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [3:0] sb[$];
  logic [3:0] exp_w;

  sipo_frame_ctrl_if #(.WIDTH(4)) bus ();

  sipo_frame_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // One clock: scoreboard pop at the negedge when a handshake is pending,
  // then return 1 time unit after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%b want=no_word", bus.out_data);
      end else begin
        exp_w = sb.pop_front();
        if (bus.out_data !== exp_w) begin
          failures++;
          $display("FAIL sb_data got=%b want=%b", bus.out_data, exp_w);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Closes a frame: sends the parity bit when parity is enabled.
  task automatic tail(input logic [3:0] d, input logic flip);
`ifdef SIPO_FRAME_PARITY_EN
    bus.sin    = (^d) ^ flip;
    bus.sin_en = 1'b1;
    cyc();
`else
    bus.sin = d[0] ^ flip;
`endif
    bus.sin_en = 1'b0;
  endtask

  // Full frame; out_ready/clr_ovr take the given values on the completing cycle.
  task automatic frame(input logic [3:0] d, input logic flip,
                       input logic rdy_last, input logic clr_last);
    bus.start  = 1'b1;
    bus.sin_en = 1'b0;
    cyc();
    bus.start = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      bus.sin    = d[i];
      bus.sin_en = 1'b1;
`ifndef SIPO_FRAME_PARITY_EN
      if (i == 0) begin
        bus.out_ready = rdy_last;
        bus.clr_ovr   = clr_last;
      end
`endif
      cyc();
    end
`ifdef SIPO_FRAME_PARITY_EN
    bus.sin       = (^d) ^ flip;
    bus.out_ready = rdy_last;
    bus.clr_ovr   = clr_last;
    cyc();
`else
    bus.sin = flip;
`endif
    bus.sin_en  = 1'b0;
    bus.clr_ovr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 0; bus.sin = 0; bus.sin_en = 0; bus.out_ready = 0; bus.clr_ovr = 0;
    cyc(); cyc();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 4'b0000) begin failures++; $display("FAIL rst_data got=%b want=0000", bus.out_data); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rst_ovr got=%b want=0", bus.overrun); end
`ifdef SIPO_FRAME_PARITY_EN
    checks++; if (bus.parity_err !== 1'b0) begin failures++; $display("FAIL rst_perr got=%b want=0", bus.parity_err); end
`endif
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    logic [3:0] d;
    d = 4'b1011;
    bus.out_ready = 1'b1;
    sb.push_back(d);
    // Serial input in the start cycle must be ignored.
    bus.start = 1'b1; bus.sin = 1'b1; bus.sin_en = 1'b1;
    cyc();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b want=1", bus.busy); end
    for (int i = 3; i >= 0; i--) begin
      bus.sin = d[i]; bus.sin_en = 1'b1;
      cyc();
      if (i == 1) begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_mid got=%b want=1", bus.busy); end
      end
    end
    tail(d, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.out_data !== d) begin failures++; $display("FAIL basic_data got=%b want=%b", bus.out_data, d); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b want=0", bus.busy); end
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b want=0", bus.out_valid); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_sb_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_gaps();
    logic [3:0] d;
    d = 4'b0011;
    bus.out_ready = 1'b1;
    sb.push_back(d);
    bus.start = 1'b1; bus.sin_en = 1'b0;
    cyc();
    bus.start = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      bus.sin = d[i]; bus.sin_en = 1'b1;
      cyc();
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          bus.sin_en = 1'b0;
          bus.sin    = ~d[i];
          bus.start  = (g == 1);  // start while busy is ignored
          cyc();
          bus.start = 1'b0;
          checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL gap_busy got=%b want=1", bus.busy); end
        end
      end
    end
    tail(d, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.out_data !== d) begin failures++; $display("FAIL gap_data got=%b want=%b", bus.out_data, d); end
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gap_valid_drop got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    sb.push_back(4'b1100);
    frame(4'b1100, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid1 got=%b want=1", bus.out_valid); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b want=0", bus.overrun); end
    // Second frame dropped; clear in the same cycle loses to the set.
    frame(4'b0110, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.out_data !== 4'b1100) begin failures++; $display("FAIL ovr_data got=%b want=1100", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid2 got=%b want=1", bus.out_valid); end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", bus.overrun); end
    cyc();
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", bus.overrun); end
    bus.clr_ovr = 1'b1;
    cyc();
    bus.clr_ovr = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b want=0", bus.overrun); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b want=0", bus.out_valid); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ovr_sb_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_same_cycle_accept();
    bus.out_ready = 1'b0;
    sb.push_back(4'b1100);
    frame(4'b1100, 1'b0, 1'b0, 1'b0);
    sb.push_back(4'b0110);
    frame(4'b0110, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL sca_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.out_data !== 4'b0110) begin failures++; $display("FAIL sca_data got=%b want=0110", bus.out_data); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL sca_ovr got=%b want=0", bus.overrun); end
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL sca_drain got=%b want=0", bus.out_valid); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sca_sb_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    frame(4'b0101, 1'b0, 1'b0, 1'b0);  // held word, flushed by reset below
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%b want=1", bus.out_valid); end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.sin = 1'b1; bus.sin_en = 1'b1;
    cyc(); cyc();
    bus.sin_en = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rm_pre_busy got=%b want=1", bus.busy); end
    reset_n = 1'b0;
    #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b want=0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 4'b0000) begin failures++; $display("FAIL rm_data got=%b want=0000", bus.out_data); end
    cyc();
    reset_n = 1'b1;
    // Bits without a start pulse are ignored.
    bus.sin = 1'b1; bus.sin_en = 1'b1;
    cyc(); cyc();
    bus.sin_en = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rm_nostart_busy got=%b want=0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_nostart_valid got=%b want=0", bus.out_valid); end
    bus.out_ready = 1'b1;
    sb.push_back(4'b1111);
    frame(4'b1111, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.out_data !== 4'b1111) begin failures++; $display("FAIL rm_data_after got=%b want=1111", bus.out_data); end
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_drain got=%b want=0", bus.out_valid); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rm_sb_left got=%0d want=0", sb.size()); end
  endtask

`ifdef SIPO_FRAME_PARITY_EN
  task automatic test_parity();
    bus.out_ready = 1'b1;
    sb.push_back(4'b1011);
    frame(4'b1011, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.parity_err !== 1'b0) begin failures++; $display("FAIL par_good got=%b want=0", bus.parity_err); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL par_good_valid got=%b want=1", bus.out_valid); end
    sb.push_back(4'b1011);
    frame(4'b1011, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.parity_err !== 1'b1) begin failures++; $display("FAIL par_bad got=%b want=1", bus.parity_err); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL par_bad_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.out_data !== 4'b1011) begin failures++; $display("FAIL par_bad_data got=%b want=1011", bus.out_data); end
    cyc();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL par_sb_left got=%0d want=0", sb.size()); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_same_cycle_accept();
    test_reset_mid();
`ifdef SIPO_FRAME_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Sequences a WIDTH-bit serial-in/parallel-out shift register.
- Frames a serial bit stream on a start pulse, counts WIDTH qualified bits, then presents the assembled word on a valid/ready output port.
- Sits between a serial source (bit strobe plus data) and a parallel consumer.
- Flags overruns when the consumer stalls.

Parameters:
- WIDTH, 4, data bits per frame (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  frame-start pulse; sampled only in IDLE.
- sin  input  1  serial data bit.
- sin_en  input  1  qualifies sin; one bit is consumed per clk with sin_en=1.
- out_data  output  WIDTH  assembled word (registered).
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
- busy  output  1  a frame is in progress (state != IDLE).
- overrun  output  1  sticky flag: a completed frame was dropped.
- clr_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, bit count=0, shift register=0.
  - out_data=0, out_valid=0, busy=0, overrun=0.
- States: IDLE, SHIFT (plus PARITY when PARITY_EN is defined).
- IDLE:
  - start=1 -> SHIFT and bit count cleared.
  - sin/sin_en are ignored in IDLE, including in the same cycle as start.
- SHIFT, each cycle with sin_en=1:
  - shift_reg <= {shift_reg[WIDTH-2:0], sin}, so the first bit received lands in the MSB.
  - Bit count increments.
- Frame completion:
  - Occurs on the edge that samples bit number WIDTH.
  - That same edge performs the completion transfer to out_data/out_valid and returns to IDLE.
  - out_valid rises on the edge that samples the final bit, so it is visible one cycle after the final sin_en.
- Cycles with sin_en=0 in SHIFT hold all state; there is no timeout.
- start asserted while not in IDLE is ignored.
- Completion transfer:
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: out_data <= new word, out_valid <= 1.
  - If out_valid=1 and out_ready=0: the new word is dropped, out_data and out_valid are unchanged, and overrun <= 1.
- Handshake:
  - out_valid=1 with out_ready=1 and no completion in that cycle -> out_valid <= 0 next cycle.
  - out_data does not change while out_valid=1 except through a same-cycle accept plus reload.
- overrun:
  - Stays set until clr_ovr=1.
  - If clr_ovr and a new overrun occur in the same cycle, set wins.
- The next frame needs a fresh start; there are no back-to-back frames without start.
- Minimum frame period is WIDTH+1 cycles (start cycle plus WIDTH bits).
- Reset asserted mid-frame aborts the frame immediately; all outputs return to reset values.

Optional Feature:
- Macro: SIPO_FRAME_PARITY_EN.
- When defined:
  - After bit WIDTH, the FSM enters PARITY.
  - The next sin_en bit is an even-parity bit over the data.
  - Completion (transfer/overrun rules unchanged) occurs on the parity edge.
  - Adds output parity_err (1 bit), registered alongside out_data with the same load rule. It is 1 when the XOR of data and the parity bit is 1.
  - parity_err resets to 0.
  - A word with bad parity is still delivered.
- When not defined:
  - No PARITY state and no parity_err port.
  - Completion occurs on bit WIDTH.

Decomposition:
- Package sipo_ctrl_pkg:
  - FSM state enum (IDLE, SHIFT, PARITY).
  - Default WIDTH constant.
  - Function computing CNT_W.
- Sub-module sipo_shift:
  - Parameterised WIDTH-bit shift register.
  - Ports: clk, reset_n, shift_en, sin, q.
- The controller instantiates one sipo_shift and owns the FSM, counter, output register and flags.

Test Plan:
- Reset, then start, then sin=1,0,1,1 on four consecutive sin_en cycles with out_ready=1 -> out_data=4'b1011 and out_valid=1 exactly one cycle after the 4th bit; out_valid=0 the following cycle; busy=1 from the start edge until completion.
- Gaps: bits 0,1 with sin_en low for 3 cycles between bits -> out_data=4'b0011, no extra shifts, busy held during the gaps.
- Stall and overrun: frame 1 = 1100 with out_ready=0, then frame 2 = 0110 -> out_data stays 4'b1100 and overrun=1; clr_ovr pulse -> overrun=0.
- Same-cycle accept: out_ready=1 on the cycle frame 2 completes -> out_data=4'b0110, out_valid stays 1, overrun stays 0.
- Reset mid-frame: reset_n low after 2 bits -> immediately busy=0, out_valid=0, out_data=0; the next start plus 1111 -> out_data=4'b1111.
- With SIPO_FRAME_PARITY_EN: data 1011 with parity 1 -> parity_err=0; data 1011 with parity 0 -> parity_err=1 and word still delivered.
